alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised, registered successor to the 32-bit combinational ALU, with a valid/ready
//  handshake on input and output. Adds status flags (carry, overflow, zero) and
//  multi-cycle logical shifts (SLL/SRL, one bit per clock). Sits between issue logic
//  and writeback; single-cycle ops sustain one result per clock.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (>=2)
//  SHW    $clog2(WIDTH)  localparam, not overridable; shift-amount width
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      async reset, active-high
//  in_valid   in   1      operand/op presented
//  in_ready   out  1      block can accept; transfer when in_valid & in_ready
//  op         in   3      000 add, 001 sub, 010 and, 011 xor, 100 sll, 101 slt, 110 srl, 111 pass a
//  a          in   WIDTH  operand A (shift source)
//  b          in   WIDTH  operand B; shifts use b[SHW-1:0] as amount, upper bits ignored
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      consumer accepts; transfer when out_valid & out_ready
//  result     out  WIDTH  registered result
//  cout       out  1      carry out (add), no-borrow (sub), else 0
//  ovf        out  1      signed overflow (add/sub), else 0
//  zero       out  1      result == 0
//  busy       out  1      high while in SHIFT state
// BEHAVIOUR
//  - States: IDLE, SHIFT, DONE. Reset (async): state=IDLE, result=0, cout=ovf=zero=0,
//    out_valid=0, busy=0, shift counter=0. in_ready is combinational: 1 after reset.
//  - in_ready = (state==IDLE) | (state==DONE & out_ready). Never high in SHIFT.
//  - Accept of non-shift op: result/flags registered at the accept edge; -> DONE.
//    Latency 1: out_valid high the cycle after accept.
//  - add: {cout,result} = a+b. sub: a + ~b + 1; cout = carry (1 when a>=b unsigned).
//    ovf = signed overflow (operand signs equal, result sign differs; for sub use ~b).
//  - slt: signed compare, result = {WIDTH-1 zeros, (a<b signed)}; cout=ovf=0.
//  - and/xor/pass: bitwise/a; cout=ovf=0. zero always reflects final result.
//  - Shift accept: acc<=a, cnt<=b[SHW-1:0]. cnt==0 -> DONE with result=a (latency 1).
//    Else -> SHIFT; each clock shifts acc by 1 (sll: zero-fill LSB; srl: zero-fill MSB)
//    and cnt--; the edge where cnt is 1 moves to DONE. Latency = 1 + shamt cycles.
//    cout=ovf=0 for shifts.
//  - DONE: out_valid=1; result/flags held stable until out_valid & out_ready.
//    On that edge: if in_valid also high, accept new op (back-to-back, no bubble);
//    else -> IDLE, out_valid=0.
//  - Inputs ignored while in_ready=0; a/b/op need only be stable on the accept edge.
//  - Reset mid-SHIFT or in DONE aborts the op immediately; pending result discarded.
//  - Width rules: all arithmetic modulo 2^WIDTH; no sign extension beyond WIDTH.
// TESTING (WIDTH=32)
//  1. add a=FFFFFFFF b=00000001 -> next cycle result=0, cout=1, zero=1, ovf=0.
//  2. sub a=80000000 b=00000001 -> 7FFFFFFF, ovf=1, cout=1; sub a=0 b=1 -> FFFFFFFF, cout=0.
//  3. slt a=FFFFFFFF b=1 -> 00000001; slt a=000000F0 b=1 -> 0, zero=1.
//  4. sll a=000000F0 b=4 -> 00000F00, out_valid exactly 5 cycles after accept,
//     busy=1 and in_ready=0 meanwhile; srl a=000000F0 b=0 -> 000000F0 after 1 cycle;
//     srl a=80000000 b=31 -> 00000001 after 32 cycles.
//  5. and a=F0 b=FF then xor, out_ready held low 3 cycles -> and result F0 stable,
//     in_ready=0; raise out_ready -> xor result 0F next cycle, one result per clock.
//  6. Assert rst during sll b=20 at cycle 10 -> out_valid=0, busy=0, in_ready=1 at once;
//     after release, add 2+3 -> 00000005 with latency 1.

Source files
------------

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Brief    : Registered ALU with valid/ready handshake, carry/overflow/zero
//            flags and bit-serial logical shifts (one bit per clock).
// Revision : 1.0 - initial release
// ============================================================================
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] c_op_add = 3'b000;
  localparam logic [2:0] c_op_sub = 3'b001;
  localparam logic [2:0] c_op_and = 3'b010;
  localparam logic [2:0] c_op_xor = 3'b011;
  localparam logic [2:0] c_op_sll = 3'b100;
  localparam logic [2:0] c_op_slt = 3'b101;
  localparam logic [2:0] c_op_srl = 3'b110;
  localparam logic [2:0] c_op_pas = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic [WIDTH-1:0] r_acc;
  logic [SHW-1:0]   r_cnt;
  logic             r_left;

  logic             w_accept;
  logic             w_is_sub;
  logic             w_is_shift;
  logic             w_long_shift;
  logic             w_lt;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_cout;
  logic             w_ovf;
  logic [WIDTH-1:0] w_acc_shifted;
  logic             w_last_shift;

  assign in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_SHIFT);
  assign result    = r_result;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

  assign w_accept     = in_valid & in_ready;
  assign w_is_sub     = (op == c_op_sub);
  assign w_is_shift   = (op == c_op_sll) | (op == c_op_srl);
  assign w_shamt      = b[SHW-1:0];
  assign w_long_shift = w_is_shift & (w_shamt != '0);
  assign w_lt         = ($signed(a) < $signed(b));

  // Subtraction reuses the adder as a + ~b + 1, so cout is the no-borrow bit.
  assign w_b_eff = w_is_sub ? ~b : b;
  assign w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_is_sub};

  assign w_acc_shifted = r_left ? {r_acc[WIDTH-2:0], 1'b0} : {1'b0, r_acc[WIDTH-1:1]};
  assign w_last_shift  = (r_cnt == SHW'(1));

  always_comb begin
    w_res  = a;
    w_cout = 1'b0;
    w_ovf  = 1'b0;
    case (op)
      c_op_add, c_op_sub: begin
        w_res  = w_sum[WIDTH-1:0];
        w_cout = w_sum[WIDTH];
        w_ovf  = (a[WIDTH-1] == w_b_eff[WIDTH-1]) & (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      c_op_and: w_res = a & b;
      c_op_xor: w_res = a ^ b;
      c_op_slt: w_res = {{(WIDTH-1){1'b0}}, w_lt};
      c_op_sll, c_op_srl, c_op_pas: w_res = a;
      default:  w_res = a;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          w_state_nxt = w_long_shift ? S_SHIFT : S_DONE;
        end else if (r_state == S_DONE && out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (w_last_shift) begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Result and flags only change when entering DONE, so they stay stable
  // while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_left   <= 1'b0;
    end else if (w_accept) begin
      r_acc  <= a;
      r_cnt  <= w_shamt;
      r_left <= (op == c_op_sll);
      if (!w_long_shift) begin
        r_result <= w_res;
        r_cout   <= w_cout;
        r_ovf    <= w_ovf;
        r_zero   <= (w_res == '0);
      end
    end else if (r_state == S_SHIFT) begin
      r_acc <= w_acc_shifted;
      r_cnt <= r_cnt - SHW'(1);
      if (w_last_shift) begin
        r_result <= w_acc_shifted;
        r_cout   <= 1'b0;
        r_ovf    <= 1'b0;
        r_zero   <= (w_acc_shifted == '0);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_pipe
// Brief    : Directed self-checking bench for alu_pipe with a result queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

  localparam logic [2:0] c_add = 3'b000;
  localparam logic [2:0] c_sub = 3'b001;
  localparam logic [2:0] c_and = 3'b010;
  localparam logic [2:0] c_xor = 3'b011;
  localparam logic [2:0] c_sll = 3'b100;
  localparam logic [2:0] c_slt = 3'b101;
  localparam logic [2:0] c_srl = 3'b110;
  localparam logic [2:0] c_pas = 3'b111;

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        cout;
  logic        ovf;
  logic        zero;
  logic        busy;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_pipe #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout required $finish");
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [32:0] s;
    logic [31:0] r;
    e = '0;
    case (o)
      c_add: begin
        s     = {1'b0, x} + {1'b0, y};
        e.res = s[31:0];
        e.c   = s[32];
        e.v   = (x[31] == y[31]) && (s[31] != x[31]);
      end
      c_sub: begin
        r     = x - y;
        e.res = r;
        e.c   = (x >= y);
        e.v   = (x[31] != y[31]) && (r[31] != x[31]);
      end
      c_and: e.res = x & y;
      c_xor: e.res = x ^ y;
      c_sll: e.res = x << y[4:0];
      c_slt: e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      c_srl: e.res = x >> y[4:0];
      default: e.res = x;
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Present one op (in_ready must already be high) and record its expectation.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    chk("in_ready_pre", {31'd0, in_ready}, 32'd1);
    op       = o;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    q.push_back(model(o, x, y));
    @(posedge clk); #1;
    in_valid = 1'b0;
    op       = 3'($urandom);
    a        = $urandom;
    b        = $urandom;
  endtask

  task automatic check_head(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      chk({tag, "_res"},  result,          e.res);
      chk({tag, "_cout"}, {31'd0, cout},   {31'd0, e.c});
      chk({tag, "_ovf"},  {31'd0, ovf},    {31'd0, e.v});
      chk({tag, "_zero"}, {31'd0, zero},   {31'd0, e.z});
    end
  endtask

  // Called one step after the accept edge; waits for out_valid, checks
  // latency and contents, then lets the handshake complete.
  task automatic collect(input string tag, input int max_cyc, input int exp_lat,
                         input bit shift_chk, output logic [31:0] obs);
    int n;
    n = 1;
    out_ready = 1'b1;
    while (!out_valid && n < max_cyc) begin
      if (shift_chk) begin
        chk({tag, "_busy"},     {31'd0, busy},     32'd1);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
      end
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_valid"},   {31'd0, out_valid}, 32'd1);
    chk({tag, "_latency"}, n,                  exp_lat);
    obs = result;
    check_head(tag);
    @(posedge clk); #1;
    chk({tag, "_drained"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] r;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 3'd0;
    a         = 32'd0;
    b         = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_result",    result,             32'd0);
    chk("rst_flags",     {29'd0, cout, ovf, zero}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Adds/subs with carry and overflow boundaries
    issue(c_add, 32'hFFFF_FFFF, 32'h0000_0001);
    collect("add_wrap", 5, 1, 1'b0, r);
    chk("add_wrap_lit", r, 32'h0000_0000);
    issue(c_sub, 32'h8000_0000, 32'h0000_0001);
    collect("sub_ovf", 5, 1, 1'b0, r);
    chk("sub_ovf_lit", r, 32'h7FFF_FFFF);
    issue(c_sub, 32'h0000_0000, 32'h0000_0001);
    collect("sub_borrow", 5, 1, 1'b0, r);
    chk("sub_borrow_lit", r, 32'hFFFF_FFFF);
    issue(c_add, 32'h7FFF_FFFF, 32'h0000_0001);
    collect("add_ovf", 5, 1, 1'b0, r);

    // Signed compare and pass-through
    issue(c_slt, 32'hFFFF_FFFF, 32'h0000_0001);
    collect("slt_neg", 5, 1, 1'b0, r);
    chk("slt_neg_lit", r, 32'h0000_0001);
    issue(c_slt, 32'h0000_00F0, 32'h0000_0001);
    collect("slt_pos", 5, 1, 1'b0, r);
    chk("slt_pos_lit", r, 32'h0000_0000);
    issue(c_pas, 32'hDEAD_BEEF, 32'h1234_5678);
    collect("pass", 5, 1, 1'b0, r);

    // Bit-serial shifts
    issue(c_sll, 32'h0000_00F0, 32'd4);
    collect("sll4", 40, 5, 1'b1, r);
    chk("sll4_lit", r, 32'h0000_0F00);
    issue(c_srl, 32'h0000_00F0, 32'd0);
    collect("srl0", 5, 1, 1'b0, r);
    chk("srl0_lit", r, 32'h0000_00F0);
    issue(c_srl, 32'h8000_0000, 32'd31);
    collect("srl31", 60, 32, 1'b1, r);
    chk("srl31_lit", r, 32'h0000_0001);
    issue(c_sll, 32'h0000_0001, 32'hFFFF_FFE1);
    collect("sll_hibits", 10, 2, 1'b1, r);
    chk("sll_hibits_lit", r, 32'h0000_0002);

    // Stalled consumer followed by a back-to-back accept
    out_ready = 1'b0;
    issue(c_and, 32'h0000_00F0, 32'h0000_00FF);
    op       = c_xor;
    a        = 32'h0000_00F0;
    b        = 32'h0000_00FF;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid",    {31'd0, out_valid}, 32'd1);
      chk("stall_result",   result,             32'h0000_00F0);
      chk("stall_in_ready", {31'd0, in_ready},  32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    check_head("and_stall");
    q.push_back(model(c_xor, 32'h0000_00F0, 32'h0000_00FF));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_valid",  {31'd0, out_valid}, 32'd1);
    chk("b2b_result", result,             32'h0000_000F);
    check_head("xor_b2b");
    @(posedge clk); #1;
    chk("b2b_drained", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of a long shift
    issue(c_sll, 32'h0000_0001, 32'd20);
    for (int i = 0; i < 8; i++) begin
      chk("rst_shift_busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy",      {31'd0, busy},      32'd0);
    chk("abort_in_ready",  {31'd0, in_ready},  32'd1);
    chk("abort_result",    result,             32'd0);
    void'(q.pop_front());
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(c_add, 32'd2, 32'd3);
    collect("add_after_rst", 5, 1, 1'b0, r);
    chk("add_after_rst_lit", r, 32'h0000_0005);

    chk("sb_left", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
